// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - core memory geometry constants and boot image loader types
// Purpose: shared BRAM geometry (byte columns, data width, depth, startup address)
//          plus the boot loader state encoding and header length.
// Macro:   BRISKI_MEM_DEPTH overrides the default BRAM depth in words.
`ifndef BRISKI_MEM_DEPTH
`define BRISKI_MEM_DEPTH 4096
`endif

package riscv_pkg;

  localparam int NB_COL    = 4;
  localparam int COL_WIDTH = 8;
  localparam int DWIDTH    = NB_COL * COL_WIDTH;

  localparam int SIZE = `BRISKI_MEM_DEPTH;

  localparam int ADDR_WIDTH   = $clog2(SIZE);
  localparam int STARTUP_ADDR = 0;

  localparam int LOADER_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - little-endian byte to 32-bit word assembler
// Purpose: counts accepted bytes and assembles them LSB first; word_valid pulses
//          combinationally on the beat carrying the fourth byte, with word showing
//          the completed value in that same cycle.
// Ports:   clk, rst_n (async active-low), clr (sync clear of partial word),
//          beat (byte accepted this cycle), rx_byte (byte value),
//          word_valid (fourth-byte beat), word (assembled word).
module byte_word_packer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              beat,
  input  logic [7:0]        rx_byte,
  output logic              word_valid,
  output logic [DWIDTH-1:0] word
);

  logic [1:0]  cnt;
  // Only the three lower bytes need storage; the top byte is taken straight
  // from the bus on the completing beat.
  logic [23:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (clr) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (beat) begin
      case (cnt)
        2'd0:    acc[7:0]   <= rx_byte;
        2'd1:    acc[15:8]  <= rx_byte;
        2'd2:    acc[23:16] <= rx_byte;
        default: ;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

  assign word_valid = beat && (cnt == 2'd3);
  assign word       = {rx_byte, acc};

endmodule

// File: rtl/bram_image_loader.sv
// rtl/bram_image_loader.sv - boot-time byte-stream writer for the unified BRAM
// Purpose: receives a header word N followed by N little-endian data words and
//          writes them to consecutive BRAM words from BASE_ADDR, holding the core
//          in reset until the image is complete.
// Macro:   LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
// Ports:   clk, rst_n (async active-low), start_i (re-arm from DONE/ERR),
//          rx_data_i/rx_valid_i/rx_ready_o (byte stream),
//          mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o (BRAM write port),
//          core_rst_n_o, busy_o, done_o, err_o, words_o (status).
module bram_image_loader
  import riscv_pkg::*;
#(
  parameter int MEM_DEPTH  = SIZE,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int BASE_ADDR  = STARTUP_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_en_o,
  output logic [NB_COL-1:0]     mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0]     mem_wdata_o,
  output logic                  core_rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   words_o
);

  localparam logic [2:0] ST_HDR  = HDR;
  localparam logic [2:0] ST_DATA = DATA;
  localparam logic [2:0] ST_CSUM = CSUM;
  localparam logic [2:0] ST_DONE = DONE;
  localparam logic [2:0] ST_ERR  = ERR;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_FINAL = ST_CSUM;
`else
  localparam logic [2:0] ST_FINAL = ST_DONE;
`endif

  localparam logic [DWIDTH-1:0]   MAX_WORDS = DWIDTH'(MEM_DEPTH - BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] ONE_W     = (ADDR_WIDTH + 1)'(1);

  logic [2:0]              state;
  logic [ADDR_WIDTH:0]     n_words;
  logic                    beat;
  logic                    last_wr;
  logic                    pk_beat;
  logic                    pk_clr;
  logic                    word_valid;
  logic [DWIDTH-1:0]       word;

  assign busy_o     = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
  assign done_o     = (state == ST_DONE);
  assign err_o      = (state == ST_ERR);
  assign rx_ready_o = busy_o;
  assign beat       = rx_valid_i && rx_ready_o;
  assign mem_we_o   = {NB_COL{mem_en_o}};

  // Write cycle of the final word: the image is complete at the end of it.
  assign last_wr = mem_en_o && (state == ST_DATA) && ((words_o + ONE_W) == n_words);

  // A byte arriving during the final write cycle already belongs to the
  // trailer, so it must not reach the packer or the running checksum.
  assign pk_beat = beat && ((state == ST_HDR) || ((state == ST_DATA) && !last_wr));
  assign pk_clr  = start_i && ((state == ST_DONE) || (state == ST_ERR));

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .beat       (pk_beat),
    .rx_byte    (rx_data_i),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign csum_ok = (rx_data_i == csum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'd0;
    end else if (pk_clr) begin
      csum <= 8'd0;
    end else if (pk_beat) begin
      csum <= csum ^ rx_data_i;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HDR;
      n_words      <= '0;
      mem_en_o     <= 1'b0;
      mem_addr_o   <= ADDR_WIDTH'(BASE_ADDR);
      mem_wdata_o  <= '0;
      words_o      <= '0;
      core_rst_n_o <= 1'b0;
    end else begin
      mem_en_o     <= 1'b0;
      // Registered release; a re-arm pulse pulls the core back into reset at once.
      core_rst_n_o <= (state == ST_DONE) && !start_i;
      case (state)
        ST_HDR: begin
          if (word_valid) begin
            if (word == '0) begin
              state <= ST_FINAL;
            end else if (word > MAX_WORDS) begin
              state <= ST_ERR;
            end else begin
              state   <= ST_DATA;
              n_words <= word[ADDR_WIDTH:0];
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            mem_en_o    <= 1'b1;
            mem_wdata_o <= word;
          end
          if (mem_en_o) begin
            words_o <= words_o + ONE_W;
            if (last_wr) begin
`ifdef LOADER_CHECKSUM_EN
              if (beat) begin
                state <= csum_ok ? ST_DONE : ST_ERR;
              end else begin
                state <= ST_CSUM;
              end
`else
              state <= ST_DONE;
`endif
            end else begin
              // Held on the last word so the address never passes MEM_DEPTH-1.
              mem_addr_o <= mem_addr_o + ADDR_WIDTH'(1);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (beat) begin
            state <= csum_ok ? ST_DONE : ST_ERR;
          end
        end
`endif
        ST_DONE, ST_ERR: begin
          if (start_i) begin
            state      <= ST_HDR;
            n_words    <= '0;
            mem_addr_o <= ADDR_WIDTH'(BASE_ADDR);
            words_o    <= '0;
          end
        end
        default: state <= ST_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_image_loader.sv
// tb/tb_bram_image_loader.sv - randomized self-checking bench for bram_image_loader
module tb_bram_image_loader;

  localparam int MEM_DEPTH = 16;
  localparam int AW        = 4;
  localparam int BASE      = 0;
  localparam int LIMIT     = MEM_DEPTH - BASE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [7:0]    rx_data_i = 8'd0;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic          mem_en_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          core_rst_n_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [AW:0]   words_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0]   exp_words[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [3:0]    we_q[$];
  int            en_long = 0;
  logic          prev_en = 1'b0;

  bram_image_loader #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_n_o (core_rst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .words_o      (words_o)
  );

  always #5 clk = ~clk;

  // Records every BRAM write seen by the bench; a write lasting more than one
  // cycle is tallied separately.
  always @(negedge clk) begin
    if (mem_en_o) begin
      wa_q.push_back(mem_addr_o);
      wd_q.push_back(mem_wdata_o);
      we_q.push_back(mem_we_o);
      if (prev_en) en_long++;
    end
    prev_en = mem_en_o;
  end

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    we_q.delete();
    en_long = 0;
  endtask

  // Number of writes that differ from the reference image (count mismatch counts once).
  function automatic int bad_writes();
    int b = 0;
    if (wd_q.size() != exp_words.size()) begin
      b++;
      $display("  write count %0d, want %0d", wd_q.size(), exp_words.size());
    end
    for (int i = 0; i < wd_q.size() && i < exp_words.size(); i++) begin
      if (wa_q[i] !== AW'(BASE + i) || wd_q[i] !== exp_words[i] || we_q[i] !== 4'hF) begin
        b++;
        $display("  write %0d: addr %0d data %h we %h, want addr %0d data %h we f",
                 i, wa_q[i], wd_q[i], we_q[i], BASE + i, exp_words[i]);
      end
    end
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Header n_hdr, then exp_words (unless the header is oversized), then the
  // XOR trailer when checksumming is built in.
  task automatic load_image(input logic [31:0] n_hdr, input bit gaps, input bit bad_csum,
                            input bit start_mid);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'd0;
    for (int k = 0; k < 4; k++) begin
      send_byte(n_hdr[8*k +: 8], gaps);
      x ^= n_hdr[8*k +: 8];
    end
    if (n_hdr > 32'(LIMIT)) return;
    for (int i = 0; i < exp_words.size(); i++) begin
      w = exp_words[i];
      for (int k = 0; k < 4; k++) begin
        if (start_mid && i == 0 && k == 2) pulse_start();
        send_byte(w[8*k +: 8], gaps);
        x ^= w[8*k +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ {7'd0, bad_csum}, gaps);
`else
    x = x ^ {7'd0, bad_csum};
`endif
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (!busy_o) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({rx_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o} !== 9'b1_0_0000_1_0_0)
      $display("FAIL reset_flags: got %b want 100000100",
               {rx_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr_o, mem_wdata_o, words_o} !== {AW'(BASE), 32'd0, 5'd0})
      $display("FAIL reset_addr_data: addr %0d data %h words %0d", mem_addr_o, mem_wdata_o, words_o);
    else pass_cnt++;
    total_cnt++;
    if (core_rst_n_o !== 1'b0) $display("FAIL reset_core_rst: got %b want 0", core_rst_n_o);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    bit to;
    int b;
    clear_mon();
    exp_words = '{32'h0000_0013, 32'h0010_0093};
    load_image(32'd2, 1'b0, 1'b0, 1'b0);
    wait_idle(to);
    total_cnt++;
    if (to || done_o !== 1'b1) $display("FAIL basic_done: done %b timeout %0d want done 1", done_o, to);
    else pass_cnt++;
    total_cnt++;
    if (core_rst_n_o !== 1'b0) $display("FAIL basic_core_rst_entry: got %b want 0", core_rst_n_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (core_rst_n_o !== 1'b1) $display("FAIL basic_core_rst_release: got %b want 1", core_rst_n_o);
    else pass_cnt++;
    b = bad_writes();
    total_cnt++;
    if (b !== 0) $display("FAIL basic_writes: %0d bad, want 0", b);
    else pass_cnt++;
    total_cnt++;
    if (words_o !== 5'd2) $display("FAIL basic_words: got %0d want 2", words_o);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    bit to;
    int b;
    int n;
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      clear_mon();
      if (r == 0) begin
        exp_words = '{32'h0000_0013, 32'h0010_0093};
      end else begin
        exp_words.delete();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      end
      load_image(32'(exp_words.size()), 1'b1, 1'b0, 1'b0);
      wait_idle(to);
      b = bad_writes();
      total_cnt++;
      if (to || done_o !== 1'b1 || b !== 0 || en_long !== 0)
        $display("FAIL gaps_%0d: done %b timeout %0d bad %0d long %0d, want done 1 others 0",
                 r, done_o, to, b, en_long);
      else pass_cnt++;
      total_cnt++;
      if (words_o !== 5'(exp_words.size()))
        $display("FAIL gaps_words_%0d: got %0d want %0d", r, words_o, exp_words.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_bounds();
    bit to;
    int b;
    pulse_start();
    clear_mon();
    exp_words.delete();
    load_image(32'd0, 1'b0, 1'b0, 1'b0);
    wait_idle(to);
    total_cnt++;
    if (to || done_o !== 1'b1 || wd_q.size() !== 0)
      $display("FAIL zero_len: done %b timeout %0d writes %0d, want 1/0/0", done_o, to, wd_q.size());
    else pass_cnt++;

    pulse_start();
    clear_mon();
    load_image(32'(MEM_DEPTH + 1), 1'b0, 1'b0, 1'b0);
    wait_idle(to);
    total_cnt++;
    if (to || err_o !== 1'b1 || rx_ready_o !== 1'b0 || wd_q.size() !== 0)
      $display("FAIL overflow: err %b ready %b writes %0d timeout %0d, want 1/0/0/0",
               err_o, rx_ready_o, wd_q.size(), to);
    else pass_cnt++;
    send_byte(8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (err_o !== 1'b1 || core_rst_n_o !== 1'b0 || words_o !== 5'd0 || wd_q.size() !== 0)
      $display("FAIL err_sticky: err %b core_rst %b words %0d writes %0d, want 1/0/0/0",
               err_o, core_rst_n_o, words_o, wd_q.size());
    else pass_cnt++;

    pulse_start();
    clear_mon();
    exp_words.delete();
    for (int i = 0; i < LIMIT; i++) exp_words.push_back($urandom);
    load_image(32'(LIMIT), 1'b1, 1'b0, 1'b0);
    wait_idle(to);
    b = bad_writes();
    total_cnt++;
    if (to || done_o !== 1'b1 || b !== 0)
      $display("FAIL full_depth: done %b timeout %0d bad %0d, want 1/0/0", done_o, to, b);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit to;
    int b;
    pulse_start();
    clear_mon();
    exp_words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    for (int k = 0; k < 4; k++) send_byte(k == 0 ? 8'd3 : 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rx_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o, core_rst_n_o} !== 10'b1_0_0000_1_0_0_0)
      $display("FAIL abort_flags: got %b want 1000001000",
               {rx_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o, core_rst_n_o});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr_o, mem_wdata_o, words_o} !== {AW'(BASE), 32'd0, 5'd0})
      $display("FAIL abort_addr_data: addr %0d data %h words %0d", mem_addr_o, mem_wdata_o, words_o);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    exp_words = '{$urandom, $urandom};
    load_image(32'd2, 1'b1, 1'b0, 1'b0);
    wait_idle(to);
    b = bad_writes();
    total_cnt++;
    if (to || done_o !== 1'b1 || b !== 0)
      $display("FAIL abort_reload: done %b timeout %0d bad %0d, want 1/0/0", done_o, to, b);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    bit to;
    int b;
    repeat (2) @(negedge clk);
    pulse_start();
    total_cnt++;
    if (core_rst_n_o !== 1'b0 || busy_o !== 1'b1 || words_o !== 5'd0)
      $display("FAIL restart_rearm: core_rst %b busy %b words %0d, want 0/1/0",
               core_rst_n_o, busy_o, words_o);
    else pass_cnt++;
    clear_mon();
    exp_words = '{32'hDEAD_BEEF};
    load_image(32'd1, 1'b0, 1'b0, 1'b1);
    wait_idle(to);
    b = bad_writes();
    total_cnt++;
    if (to || done_o !== 1'b1 || b !== 0)
      $display("FAIL restart_load: done %b timeout %0d bad %0d, want 1/0/0", done_o, to, b);
    else pass_cnt++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit to;
    int b;
    pulse_start();
    clear_mon();
    exp_words = '{$urandom, $urandom, $urandom};
    load_image(32'd3, 1'b1, 1'b0, 1'b0);
    wait_idle(to);
    b = bad_writes();
    total_cnt++;
    if (to || done_o !== 1'b1 || b !== 0)
      $display("FAIL csum_good: done %b timeout %0d bad %0d, want 1/0/0", done_o, to, b);
    else pass_cnt++;
    pulse_start();
    clear_mon();
    load_image(32'd3, 1'b0, 1'b1, 1'b0);
    wait_idle(to);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (to || err_o !== 1'b1 || core_rst_n_o !== 1'b0)
      $display("FAIL csum_bad: err %b core_rst %b timeout %0d, want 1/0/0", err_o, core_rst_n_o, to);
    else pass_cnt++;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_gaps();
    test_bounds();
    test_abort();
    test_restart();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
